serial_word_rx: RTL and testbench
=================================

Name: serial_word_rx

Overview:
Downstream consumer of the 5-bit universal shift register's serial output (so). Receives a framed serial bit stream: start bit 0, WIDTH data bits, optional parity, stop bit 1. Deserializes each frame into a parallel word, LSB-first or MSB-first. Presents the word on a valid/ready handshake with a single holding register, and flags framing errors and overruns.

Parameters:
WIDTH, 5, data bits per frame; matches shift register width; legal range 2..16.
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
bit_in  in  1  serial data (shift register so)
bit_valid  in  1  qualifies bit_in for this cycle; no state advance when 0
msb_first  in  1  1 = first data bit is the word MSB; 0 = first data bit is the LSB; sampled at start bit only
dout  out  WIDTH  received word
dout_valid  out  1  dout holds an unconsumed word
dout_ready  in  1  consumer accepts dout when dout_valid & dout_ready
busy  out  1  frame in progress (state != IDLE)
frame_err  out  1  one-cycle pulse: stop bit sampled as 0
overrun  out  1  one-cycle pulse: completed word dropped because holding register full
parity_err  out  1  one-cycle pulse: parity mismatch (constant 0 unless PARITY_EN)

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, bit count 0, shift reg 0, dout 0, dout_valid 0, frame_err/overrun/parity_err 0. Reset wins over every event, including mid-frame; the partial frame is discarded.
- Only cycles with bit_valid=1 advance the FSM or the shift register. Gaps of any length are transparent.
- IDLE: valid bit_in=0 -> DATA, count<=0, latch msb_first into dir. Valid bit_in=1 -> stay (line idle).
- DATA: each valid bit: dir=1 -> shift<={shift[WIDTH-2:0],bit_in}; dir=0 -> shift<={bit_in,shift[WIDTH-1:1]}; count++. On the WIDTH-th bit -> PARITY if PARITY_EN, else STOP.
- PARITY (PARITY_EN only): valid bit stored as pbit -> STOP.
- STOP: valid bit -> IDLE always.
  - Stop=0: frame_err pulses next cycle; word discarded.
  - Stop=1 and parity bad: parity_err pulses next cycle; word discarded.
  - Stop=1 and parity good (or no parity): deliver.
- Deliver: if dout_valid=0, or dout_valid&dout_ready in the same cycle, then dout<=shift and dout_valid<=1; visible the cycle after the stop bit sample (latency 1).
- Deliver when dout_valid=1 and dout_ready=0: dout unchanged; overrun pulses next cycle; new word dropped.
- Handshake: dout_valid&dout_ready with no simultaneous delivery -> dout_valid<=0 next cycle. dout holds its last value. dout and dout_valid never change while dout_valid=1 and dout_ready=0.
- dout_ready is ignored while dout_valid=0.
- busy is combinational from state.
- frame_err, overrun and parity_err are registered pulses, exactly one cycle wide; at most one of them per frame.

Optional Feature:
SERIAL_RX_PARITY_EN
- Defined: PARITY state is inserted after the data bits; even parity over data+pbit; mismatch discards the word and pulses parity_err.
- Undefined: no PARITY state; frame is start+WIDTH+stop; parity_err tied 0.

Decomposition:
- Package sr_pkg: state encodings (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3), SR_WIDTH=5 default, even-parity function.
- One sub-module, sr_out_hold: the holding register with valid/ready/overrun logic, parameterized by WIDTH.
- The FSM, counter and shifter stay in serial_word_rx.

Test Plan:
1. LSB-first, WIDTH=5, dout_ready=1: bits 0 | 1,0,1,1,0 | 1 -> dout=5'b01101, dout_valid high one cycle after stop, low the following cycle.
2. MSB-first, same stream -> dout=5'b10110; busy high from the cycle after the start bit through the stop bit.
3. Stop bit 0 on a 5'b01101 frame -> frame_err one-cycle pulse, dout_valid stays 0, next good frame received normally.
4. dout_ready=0: frame 5'b01101 then frame 5'b10010 -> dout stays 5'b01101, overrun pulses once. Raise ready -> handshake clears dout_valid.
5. Random bit_valid gaps of 0-4 cycles in frame 1, identical result. rst=0 after 3 data bits -> IDLE and all outputs 0; next frame 5'b11111 decodes correctly.
6. With SERIAL_RX_PARITY_EN: data 5'b01101, pbit=0 (odd total) -> parity_err pulse, no dout_valid. pbit=1 -> dout=5'b01101 delivered.

Source files
------------

// File: rtl/sr_pkg.sv
// sr_pkg: shared definitions for the serial word receiver.
//   state_e      - receiver FSM state encodings
//   SR_WIDTH     - default word width (matches the 5-bit shift register)
//   even_parity  - XOR reduction; 0 means an even number of ones
package sr_pkg;

  localparam int SR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Callers zero-extend to 16 bits; padding zeros do not change the result.
  function automatic logic even_parity(input logic [15:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sr_out_hold.sv
// sr_out_hold: single-entry holding register on a valid/ready interface.
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   wr_en, wr_data  - a completed word offered by the receiver (one cycle)
//   dout_ready      - consumer accept
//   dout            - held word
//   dout_valid      - dout holds an unconsumed word
//   overrun         - one-cycle pulse: offered word dropped because the register was full
module sr_out_hold #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             accept;

  // dout_ready only matters while a word is held.
  assign accept = dout_valid_q & dout_ready;

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    if (wr_en) begin
      // A word consumed this cycle frees the slot for the incoming one.
      if (!dout_valid_q || accept) begin
        dout_d       = wr_data;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx: deserializes framed serial bits (start 0, WIDTH data bits,
// optional even parity, stop 1) into a word on a valid/ready output.
// Optional feature macro: SERIAL_RX_PARITY_EN inserts a parity bit after data.
// Ports:
//   clk, rst     - clock, synchronous active-low reset
//   bit_in       - serial data; bit_valid qualifies it (no advance when 0)
//   msb_first    - bit order, captured at the start bit
//   dout, dout_valid, dout_ready - received word handshake
//   busy         - frame in progress
//   frame_err    - pulse: stop bit was 0
//   overrun      - pulse: word dropped, holding register full
//   parity_err   - pulse: parity mismatch (0 without SERIAL_RX_PARITY_EN)
module serial_word_rx
  import sr_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             msb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             dir_q, dir_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             deliver;
  logic             par_ok;

`ifdef SERIAL_RX_PARITY_EN
  logic pbit_q, pbit_d;
  // Even parity: data plus parity bit must hold an even number of ones.
  assign par_ok = ~(even_parity(16'(shift_q)) ^ pbit_q);
`else
  assign par_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      case (state_q)
        ST_IDLE: if (!bit_in) state_d = ST_DATA;
        ST_DATA: begin
          if (cnt_q == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY: state_d = ST_STOP;
`endif
        ST_STOP:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output / event logic: the stop-bit sample decides the frame's fate.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    deliver      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (bit_valid && state_q == ST_STOP) begin
      if (!bit_in)      frame_err_d  = 1'b1;
      else if (!par_ok) parity_err_d = 1'b1;
      else              deliver      = 1'b1;
    end
  end

  // Datapath: bit counter, shifter, direction latch
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dir_d   = dir_q;
`ifdef SERIAL_RX_PARITY_EN
    pbit_d  = pbit_q;
`endif
    if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            cnt_d = '0;
            dir_d = msb_first;
          end
        end
        ST_DATA: begin
          shift_d = dir_q ? {shift_q[WIDTH-2:0], bit_in}
                          : {bit_in, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
        end
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY: pbit_d = bit_in;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      dir_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      pbit_q       <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      dir_q        <= dir_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef SERIAL_RX_PARITY_EN
      pbit_q       <= pbit_d;
`endif
    end
  end

  sr_out_hold #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (deliver),
    .wr_data    (shift_q),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

  assign frame_err = frame_err_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx (WIDTH=5). Inputs change on the falling
// edge; outputs are checked on the falling edge after the rising edge that
// consumed them.
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       msb_first;
  logic [4:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  serial_word_rx dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .msb_first  (msb_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One valid bit; returns on the falling edge after it was sampled.
  task automatic send(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b1;
  endtask

  task automatic idle_gap(input bit gaps);
    if (gaps) repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  // Full frame of word w. LSB-first sends w[0] first, MSB-first sends w[4] first.
  task automatic send_frame(input logic [4:0] w, input logic msb, input logic stop_b,
                            input logic pbit, input bit gaps, input bit rdy_stop);
    msb_first = msb;
    send(1'b0);
    msb_first = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle_gap(gaps);
      send(msb ? w[4-i] : w[i]);
    end
`ifdef SERIAL_RX_PARITY_EN
    idle_gap(gaps);
    send(pbit);
`else
    if (pbit) ;
`endif
    idle_gap(gaps);
    if (rdy_stop) dout_ready = 1'b1;
    send(stop_b);
  endtask

  initial begin
    rst        = 1'b0;
    bit_in     = 1'b1;
    bit_valid  = 1'b0;
    msb_first  = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_dout",   16'(dout), 16'h0);
    chk("rst_valid",  16'(dout_valid), 16'h0);
    chk("rst_busy",   16'(busy), 16'h0);
    chk("rst_ferr",   16'(frame_err), 16'h0);
    chk("rst_ovr",    16'(overrun), 16'h0);
    chk("rst_perr",   16'(parity_err), 16'h0);
    rst = 1'b1;
    @(negedge clk);

    // 1: LSB-first, stream 1,0,1,1,0
    send_frame(5'b01101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_dout",  16'(dout), 16'h0d);
    chk("t1_valid", 16'(dout_valid), 16'h1);
    chk("t1_perr",  16'(parity_err), 16'h0);
    @(negedge clk);
    chk("t1_valid_clr", 16'(dout_valid), 16'h0);
    chk("t1_dout_hold", 16'(dout), 16'h0d);

    // 2: MSB-first, same stream 1,0,1,1,0 -> 10110
    msb_first = 1'b1;
    send(1'b0);
    msb_first = 1'b0;
    chk("t2_busy_start", 16'(busy), 16'h1);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b0);
`ifdef SERIAL_RX_PARITY_EN
    send(1'b1);
`endif
    chk("t2_busy_stop", 16'(busy), 16'h1);
    send(1'b1);
    chk("t2_dout",  16'(dout), 16'h16);
    chk("t2_valid", 16'(dout_valid), 16'h1);
    chk("t2_busy_idle", 16'(busy), 16'h0);
    @(negedge clk);

    // 3: bad stop bit
    send_frame(5'b01101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_ferr",  16'(frame_err), 16'h1);
    chk("t3_valid", 16'(dout_valid), 16'h0);
    @(negedge clk);
    chk("t3_ferr_pulse", 16'(frame_err), 16'h0);
    send_frame(5'b01101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_dout_next",  16'(dout), 16'h0d);
    chk("t3_valid_next", 16'(dout_valid), 16'h1);
    @(negedge clk);

    // 4: overrun while held, then handshake
    dout_ready = 1'b0;
    send_frame(5'b01101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_dout_a", 16'(dout), 16'h0d);
    send_frame(5'b10010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_ovr",       16'(overrun), 16'h1);
    chk("t4_dout_keep", 16'(dout), 16'h0d);
    chk("t4_valid_keep", 16'(dout_valid), 16'h1);
    @(negedge clk);
    chk("t4_ovr_pulse", 16'(overrun), 16'h0);
    // accept and deliver in the same cycle: new word replaces, no overrun
    send_frame(5'b00011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_swap_dout",  16'(dout), 16'h03);
    chk("t4_swap_valid", 16'(dout_valid), 16'h1);
    chk("t4_swap_ovr",   16'(overrun), 16'h0);
    @(negedge clk);
    chk("t4_hs_clr",  16'(dout_valid), 16'h0);
    chk("t4_hs_dout", 16'(dout), 16'h03);

    // 5: random gaps, then reset mid-frame
    dout_ready = 1'b0;
    send_frame(5'b01101, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_gap_dout",  16'(dout), 16'h0d);
    chk("t5_gap_valid", 16'(dout_valid), 16'h1);
    send(1'b0); send(1'b1); send(1'b0); send(1'b1);
    chk("t5_busy_mid", 16'(busy), 16'h1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_rst_busy",  16'(busy), 16'h0);
    chk("t5_rst_valid", 16'(dout_valid), 16'h0);
    chk("t5_rst_dout",  16'(dout), 16'h0);
    dout_ready = 1'b1;
    send_frame(5'b11111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_ones_dout",  16'(dout), 16'h1f);
    chk("t5_ones_valid", 16'(dout_valid), 16'h1);
    @(negedge clk);

`ifdef SERIAL_RX_PARITY_EN
    // 6: parity
    send_frame(5'b01101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_perr",  16'(parity_err), 16'h1);
    chk("t6_valid", 16'(dout_valid), 16'h0);
    @(negedge clk);
    chk("t6_perr_pulse", 16'(parity_err), 16'h0);
    send_frame(5'b01101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_dout",  16'(dout), 16'h0d);
    chk("t6_valid_ok", 16'(dout_valid), 16'h1);
    chk("t6_perr_ok",  16'(parity_err), 16'h0);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
